// File: rtl/nco_pkg.sv
// nco_pkg: shared widths and FSM state encoding for the sine NCO
package nco_pkg;
    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 16;
    localparam int SAMPLE_W   = 8;
    localparam int OUT_W      = 16;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t FETCH   = 2'd1;
    localparam state_t CAPTURE = 2'd2;
    localparam state_t OUT     = 2'd3;
endpackage

// File: rtl/phase_acc.sv
// phase_acc: tuning-word register and phase accumulator; ports: clk, rst, freq_in/freq_load (tuning word), phase_clear, advance (one step), idx (9-bit table index)
module phase_acc
    import nco_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_W-1:0]    freq_in,
    input  logic                  freq_load,
    input  logic                  phase_clear,
    input  logic                  advance,
    output logic [ROM_ADDR_W:0]   idx
);
    logic [PHASE_W-1:0] freq_reg;
    logic [PHASE_W-1:0] phase;
    // clear beats advance; the add always uses the step held before this edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            freq_reg <= '0;
            phase    <= '0;
        end else begin
            if (freq_load) freq_reg <= freq_in;
            phase <= phase_clear ? '0 : advance ? phase + freq_reg : phase;
        end
    assign idx = phase[PHASE_W-1 -: ROM_ADDR_W+1];
endmodule

// File: rtl/sine_nco.sv
// sine_nco: NCO front end for the packed 512x8 sine ROM; ports: clk, rst, enable, freq_in/freq_load, phase_clear, gain, rom_en/rom_addr/rom_dout (ROM side), out_valid/out_ready/out_data (sample stream)
module sine_nco
    import nco_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PHASE_W-1:0]     freq_in,
    input  logic                   freq_load,
    input  logic                   phase_clear,
    input  logic [7:0]             gain,
    output logic                   rom_en,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    input  logic [ROM_DATA_W-1:0]  rom_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data
);
    state_t state;
    logic byte_sel;
    logic [ROM_ADDR_W:0] idx;
    logic [SAMPLE_W-1:0] b;
    logic signed [OUT_W-1:0] s_ext, g_ext, prod;
    phase_acc #(.PHASE_W(PHASE_W)) u_acc (
        .clk         (clk),
        .rst         (rst),
        .freq_in     (freq_in),
        .freq_load   (freq_load),
        .phase_clear (phase_clear),
        .advance     (state == FETCH),
        .idx         (idx)
    );
    assign rom_en   = state == FETCH;
    assign rom_addr = idx[ROM_ADDR_W:1];
    assign b        = byte_sel ? rom_dout[ROM_DATA_W-1 -: SAMPLE_W] : rom_dout[SAMPLE_W-1:0];
    // offset-binary to two's complement is just an inverted MSB, sign-extended here
    assign s_ext    = {{(OUT_W-SAMPLE_W+1){~b[SAMPLE_W-1]}}, b[SAMPLE_W-2:0]};
    assign g_ext    = {{(OUT_W-8){1'b0}}, gain};
    // product magnitude fits in OUT_W bits, so the truncated product is exact
    assign prod     = s_ext * g_ext;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            byte_sel  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE:    if (enable) state <= FETCH;
                FETCH: begin
                    byte_sel <= idx[0];
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= prod;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= enable ? FETCH : IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_sine_nco.sv
// tb_sine_nco: directed self-checking bench for sine_nco with an inline ROM model
module tb_sine_nco;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] freq_in = '0;
    logic        freq_load = 1'b0;
    logic        phase_clear = 1'b0;
    logic [7:0]  gain = '0;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sine_nco #(.PHASE_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .freq_in     (freq_in),
        .freq_load   (freq_load),
        .phase_clear (phase_clear),
        .gain        (gain),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // offset-binary table bytes; the indices the tests use are pinned, the rest are arbitrary
    function automatic logic [7:0] rom_byte(input logic [8:0] i);
        case (i)
            9'd0:    return 8'h7F;
            9'd1:    return 8'h80;
            9'd2:    return 8'h82;
            9'd128:  return 8'hFE;
            9'd510:  return 8'h7B;
            9'd511:  return 8'h7D;
            default: return i[7:0] ^ 8'h55;
        endcase
    endfunction

    always @(posedge clk)
        if (rom_en) rom_dout <= {rom_byte({rom_addr, 1'b1}), rom_byte({rom_addr, 1'b0})};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic get_sample(input string tag, output logic [15:0] d, output int c);
        d = 'x;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                d = out_data;
                c = cyc;
                return;
            end
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic expect_sample(input string tag, input logic [15:0] exp);
        logic [15:0] d;
        int c;
        get_sample(tag, d, c);
        chk(tag, d, exp);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic setup(input logic [23:0] f, input logic [7:0] g);
        freq_in = f;
        gain = g;
        freq_load = 1'b1;
        phase_clear = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        phase_clear = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        int c1, c2, c3;
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        freq_in = 24'h008000;
        freq_load = 1'b1;
        gain = 8'd1;
        enable = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        get_sample("step0", d, c1);
        chk("step0", d, 16'hFFFF);
        get_sample("step1", d, c2);
        chk("step1", d, 16'h0000);
        get_sample("step2", d, c3);
        chk("step2", d, 16'h0002);
        chk("step_gap1", c2 - c1, 3);
        chk("step_gap2", c3 - c2, 3);

        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rom_en;
        end
        chk("rst_find_fetch", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_rom_en", rom_en, 0);
        @(negedge clk);
        rst = 1'b0;
        expect_sample("rst_first", 16'hFFFF);

        go_idle();
        setup(24'hFF8000, 8'd1);
        expect_sample("wrap0", 16'hFFFF);
        expect_sample("wrap511", 16'hFFFD);
        expect_sample("wrap510", 16'hFFFB);

        go_idle();
        setup(24'h400000, 8'h80);
        expect_sample("quart0", 16'hFF80);
        expect_sample("quart128", 16'h3F00);
        @(negedge clk);
        out_ready = 1'b0;
        expect_sample("bp_sample", 16'hEA80);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", out_data, 16'hEA80);
            chk("bp_valid", out_valid, 1);
            chk("bp_rom_en", rom_en, 0);
            chk("bp_addr", rom_addr, 8'hC0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_fetch", rom_en, 1);
        chk("bp_drop", out_valid, 0);
        expect_sample("bp_next", 16'h2A80);

        go_idle();
        setup(24'h008000, 8'd1);
        expect_sample("clr_pre", 16'hFFFF);
        @(negedge clk);
        chk("clr_in_fetch", rom_en, 1);
        phase_clear = 1'b1;
        @(negedge clk);
        phase_clear = 1'b0;
        get_sample("clr_cur", d, c1);
        chk("clr_cur", d, 16'h0000);
        get_sample("clr_next", d, c1);
        chk("clr_next", d, 16'hFFFF);
        freq_in = 24'h010000;
        freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        expect_sample("ld_old", 16'h0000);
        expect_sample("ld_new", 16'hFFD6);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_idle_rom_en", rom_en, 0);
            chk("en_idle_valid", out_valid, 0);
        end
        enable = 1'b1;
        expect_sample("en_resume", 16'hFFD0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
